radio_sched: RTL and testbench

Multi-channel RC receiver front end and scheduler. It measures NCH PWM servo channels in parallel and time-shares one clamp/offset conversion unit between them. Completed samples go out as a single valid/ready stream, with round-robin fairness and per-channel loss-of-signal failsafe. It sits between the receiver pins and the flight-control register file, replacing per-channel free-running capture blocks.

---
 rtl/radio_pkg.sv | 33 +++
 rtl/radio_chan.sv | 83 ++++++++
 rtl/radio_sched.sv | 122 ++++++++++++
 tb/tb_radio_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/radio_pkg.sv
// Shared definitions for the radio receiver blocks: widths, arbiter
// state encoding and the pulse-width to value conversion.
package radio_pkg;

    localparam int VAL_W = 10;
    localparam int RAW_W = 11;
    localparam int SIL_W = 15;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_HOLD = 1'b1
    } arb_state_t;

    // Clamp a measured pulse width into the 0..1023 value range around offset.
    function automatic logic [VAL_W-1:0] convert_raw(
        input logic [RAW_W-1:0] raw,
        input logic             fs,
        input logic [RAW_W-1:0] offset,
        input logic [VAL_W-1:0] dflt
    );
        logic [RAW_W:0] hi;
        hi = {1'b0, offset} + 12'd1023;
        if (fs)
            return dflt;
        else if (raw < offset)
            return '0;
        else if ({1'b0, raw} > hi)
            return {VAL_W{1'b1}};
        else
            return VAL_W'(raw - offset);
    endfunction

endpackage

// File: rtl/radio_chan.sv
// One PWM channel: synchronizer, pulse-width measurement, glitch filter,
// loss-of-signal timer and the pending sample flags seen by the arbiter.
module radio_chan
    import radio_pkg::*;
#(
    parameter logic [RAW_W-1:0] GLITCH  = 11'd500,
    parameter logic [SIL_W-1:0] TIMEOUT = 15'd25000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sig,
    input  logic             clear_pending,
    output logic [RAW_W-1:0] raw,
    output logic             pending,
    output logic             fs_req,
    output logic             failsafe
);

    logic             sync0, sync1, sync_d;
    logic [RAW_W-1:0] width;
    logic [SIL_W-1:0] silence;
    logic             rise, fall, valid_fall, timeout_hit;

    assign rise        = sync1 & ~sync_d;
    assign fall        = ~sync1 & sync_d;
    assign valid_fall  = fall && (width >= GLITCH);
    assign timeout_hit = !valid_fall && (silence != TIMEOUT) && (silence == TIMEOUT - 15'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0  <= 1'b0;
            sync1  <= 1'b0;
            sync_d <= 1'b0;
        end else begin
            sync0  <= sig;
            sync1  <= sync0;
            sync_d <= sync1;
        end
    end

    // The rising-edge cycle is itself a high cycle, so the count restarts at 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            width <= '0;
        else if (rise)
            width <= 11'd1;
        else if (sync1 && width != {RAW_W{1'b1}})
            width <= width + 11'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            silence <= '0;
        else if (valid_fall)
            silence <= '0;
        else if (silence != TIMEOUT)
            silence <= silence + 15'd1;
    end

    // A fresh capture outranks a grant clear so a sample is never dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            raw      <= '0;
            pending  <= 1'b0;
            fs_req   <= 1'b0;
            failsafe <= 1'b1;
        end else begin
            if (valid_fall) begin
                raw      <= width;
                pending  <= 1'b1;
                fs_req   <= 1'b0;
                failsafe <= 1'b0;
            end else if (timeout_hit) begin
                pending  <= 1'b1;
                fs_req   <= 1'b1;
                failsafe <= 1'b1;
            end else if (clear_pending) begin
                pending  <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/radio_sched.sv
// Multi-channel RC receiver front end: per-channel capture, a round-robin
// arbiter and one shared conversion unit feeding a valid/ready stream.
module radio_sched
    import radio_pkg::*;
#(
    parameter int               NCH     = 6,
    parameter logic [VAL_W-1:0] DEFAULT = 10'd512,
    parameter logic [RAW_W-1:0] OFFSET  = 11'd987,
    parameter logic [RAW_W-1:0] GLITCH  = 11'd500,
    parameter logic [SIL_W-1:0] TIMEOUT = 15'd25000
) (
    input  logic             tmr_1Mhz,
    input  logic             rst_n,
    input  logic [NCH-1:0]   sig,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2:0]       out_ch,
    output logic [VAL_W-1:0] out_val,
    output logic [NCH-1:0]   failsafe
);

    logic [RAW_W-1:0] raw_arr [NCH];
    logic [NCH-1:0]   pending, fs_req, clear_vec;
    arb_state_t       state_q, state_d;
    logic [2:0]       ptr, grant, next_ptr;
    logic             found, load;
    logic [RAW_W-1:0] sel_raw;
    logic             sel_fs;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        radio_chan #(
            .GLITCH  (GLITCH),
            .TIMEOUT (TIMEOUT)
        ) u_chan (
            .clk           (tmr_1Mhz),
            .rst_n         (rst_n),
            .sig           (sig[i]),
            .clear_pending (clear_vec[i]),
            .raw           (raw_arr[i]),
            .pending       (pending[i]),
            .fs_req        (fs_req[i]),
            .failsafe      (failsafe[i])
        );
    end

    // Two passes: first pending at or above the pointer, else wrap to the lowest.
    always_comb begin
        found = 1'b0;
        grant = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!found && pending[i] && i >= int'(ptr)) begin
                found = 1'b1;
                grant = 3'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!found && pending[i]) begin
                found = 1'b1;
                grant = 3'(i);
            end
        end
        next_ptr = (grant == 3'(NCH - 1)) ? 3'd0 : grant + 3'd1;
    end

    always_comb begin
        sel_raw = '0;
        sel_fs  = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (grant == 3'(i)) begin
                sel_raw = raw_arr[i];
                sel_fs  = fs_req[i];
            end
        end
    end

    always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
        if (!rst_n)
            state_q <= ARB_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (found) begin
                    load    = 1'b1;
                    state_d = ARB_HOLD;
                end
            end
            ARB_HOLD: begin
                if (out_ready)
                    state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_comb begin
        clear_vec = '0;
        for (int i = 0; i < NCH; i++)
            clear_vec[i] = load && (grant == 3'(i));
    end

    // Outputs only load on a grant, which keeps them frozen through a stall.
    always_ff @(posedge tmr_1Mhz or negedge rst_n) begin
        if (!rst_n) begin
            out_ch  <= '0;
            out_val <= '0;
            ptr     <= '0;
        end else if (load) begin
            out_ch  <= grant;
            out_val <= convert_raw(sel_raw, sel_fs, OFFSET, DEFAULT);
            ptr     <= next_ptr;
        end
    end

    assign out_valid = (state_q == ARB_HOLD);

endmodule

// File: tb/tb_radio_sched.sv
// Directed self-checking bench for radio_sched: single-pulse vector table
// plus hand-written sequences for arbitration, timeout and reset.
module tb_radio_sched;

    localparam int NCH = 6;

    logic           tmr_1Mhz;
    logic           rst_n;
    logic [NCH-1:0] sig;
    logic           out_valid;
    logic           out_ready;
    logic [2:0]     out_ch;
    logic [9:0]     out_val;
    logic [NCH-1:0] failsafe;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] ch;
        logic [9:0] val;
    } sample_t;

    typedef struct {
        logic [NCH-1:0] mask;
        int             width;
        bit             expect_sample;
        int             exp_ch;
        int             exp_val;
        logic [NCH-1:0] exp_fs;
    } vec_t;

    sample_t q[$];
    vec_t    vecs[7];

    radio_sched #(.NCH(NCH)) dut (
        .tmr_1Mhz  (tmr_1Mhz),
        .rst_n     (rst_n),
        .sig       (sig),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_val   (out_val),
        .failsafe  (failsafe)
    );

    initial tmr_1Mhz = 1'b0;
    always #5 tmr_1Mhz = ~tmr_1Mhz;

    // Record a handshake half a cycle before the edge that completes it.
    always @(negedge tmr_1Mhz) begin
        if (rst_n && out_valid && out_ready)
            q.push_back('{ch: out_ch, val: out_val});
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        @(posedge tmr_1Mhz) #1;
        rst_n = 1'b0;
        sig   = '0;
        repeat (3) @(posedge tmr_1Mhz);
        #1 rst_n = 1'b1;
        q.delete();
    endtask

    task automatic apply_stimulus(input logic [NCH-1:0] mask, input int width);
        @(posedge tmr_1Mhz) #1;
        sig = sig | mask;
        repeat (width) @(posedge tmr_1Mhz);
        #1 sig = sig & ~mask;
    endtask

    task automatic wait_sample(input int budget, output bit got, output sample_t s);
        got = 1'b0;
        s   = '{ch: '0, val: '0};
        for (int c = 0; c < budget && !got; c++) begin
            @(posedge tmr_1Mhz);
            if (q.size() > 0) begin
                s   = q.pop_front();
                got = 1'b1;
            end
        end
    endtask

    task automatic wait_valid(input int budget, output bit got);
        got = 1'b0;
        for (int c = 0; c < budget && !got; c++) begin
            @(negedge tmr_1Mhz);
            if (out_valid === 1'b1) got = 1'b1;
        end
    endtask

    initial begin
        bit      got, stable;
        sample_t s;
        int      n4, n_def;
        int      exp_order[4];
        int      exp_vals[4];

        vecs[0] = '{mask: 6'b000100, width: 1500, expect_sample: 1, exp_ch: 2, exp_val: 513,  exp_fs: 6'b111011};
        vecs[1] = '{mask: 6'b000001, width: 900,  expect_sample: 1, exp_ch: 0, exp_val: 0,    exp_fs: 6'b111010};
        vecs[2] = '{mask: 6'b000001, width: 987,  expect_sample: 1, exp_ch: 0, exp_val: 0,    exp_fs: 6'b111010};
        vecs[3] = '{mask: 6'b000001, width: 2010, expect_sample: 1, exp_ch: 0, exp_val: 1023, exp_fs: 6'b111010};
        vecs[4] = '{mask: 6'b000001, width: 2100, expect_sample: 1, exp_ch: 0, exp_val: 1023, exp_fs: 6'b111010};
        vecs[5] = '{mask: 6'b000010, width: 300,  expect_sample: 0, exp_ch: 0, exp_val: 0,    exp_fs: 6'b111010};
        vecs[6] = '{mask: 6'b000010, width: 1000, expect_sample: 1, exp_ch: 1, exp_val: 13,   exp_fs: 6'b111000};

        rst_n     = 1'b1;
        sig       = '0;
        out_ready = 1'b0;

        // Reset values while reset is held.
        @(posedge tmr_1Mhz) #1 rst_n = 1'b0;
        #2;
        check_output("rst_valid", 32'(out_valid), 0);
        check_output("rst_ch", 32'(out_ch), 0);
        check_output("rst_val", 32'(out_val), 0);
        check_output("rst_failsafe", 32'(failsafe), 32'h3f);

        // Single-pulse table.
        do_reset();
        out_ready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            q.delete();
            apply_stimulus(vecs[v].mask, vecs[v].width);
            if (vecs[v].expect_sample) begin
                wait_sample(40, got, s);
                check_output($sformatf("vec%0d_got", v), 32'(got), 1);
                check_output($sformatf("vec%0d_ch", v), 32'(s.ch), 32'(vecs[v].exp_ch));
                check_output($sformatf("vec%0d_val", v), 32'(s.val), 32'(vecs[v].exp_val));
            end else begin
                repeat (40) @(posedge tmr_1Mhz);
                check_output($sformatf("vec%0d_none", v), 32'(q.size()), 0);
            end
            @(negedge tmr_1Mhz);
            check_output($sformatf("vec%0d_fs", v), 32'(failsafe), 32'(vecs[v].exp_fs));
            repeat (5) @(posedge tmr_1Mhz);
        end

        // Round robin with a 20-cycle stall on the first grant.
        do_reset();
        out_ready = 1'b0;
        apply_stimulus(6'b101001, 1200);
        wait_valid(20, got);
        check_output("rr1_valid", 32'(got), 1);
        stable = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge tmr_1Mhz);
            if (out_valid !== 1'b1 || out_ch !== 3'd0 || out_val !== 10'd213) stable = 1'b0;
        end
        check_output("rr1_stall_stable", 32'(stable), 1);
        @(posedge tmr_1Mhz) #1 out_ready = 1'b1;
        exp_order = '{0, 3, 5, 0};
        for (int k = 0; k < 3; k++) begin
            wait_sample(20, got, s);
            check_output($sformatf("rr1_got%0d", k), 32'(got), 1);
            check_output($sformatf("rr1_ch%0d", k), 32'(s.ch), 32'(exp_order[k]));
            check_output($sformatf("rr1_val%0d", k), 32'(s.val), 213);
        end

        // Second round: ch0 re-captures while held, so it waits behind 3 and 5.
        repeat (10) @(posedge tmr_1Mhz);
        #1 out_ready = 1'b0;
        q.delete();
        apply_stimulus(6'b101001, 1200);
        wait_valid(20, got);
        check_output("rr2_valid", 32'(got), 1);
        check_output("rr2_first_ch", 32'(out_ch), 0);
        apply_stimulus(6'b000001, 1100);
        repeat (10) @(posedge tmr_1Mhz);
        #1 out_ready = 1'b1;
        exp_vals = '{213, 213, 213, 113};
        for (int k = 0; k < 4; k++) begin
            wait_sample(20, got, s);
            check_output($sformatf("rr2_got%0d", k), 32'(got), 1);
            check_output($sformatf("rr2_ch%0d", k), 32'(s.ch), 32'(exp_order[k]));
            check_output($sformatf("rr2_val%0d", k), 32'(s.val), 32'(exp_vals[k]));
        end

        // Loss of signal on ch4; the never-driven channels time out as well.
        do_reset();
        out_ready = 1'b1;
        apply_stimulus(6'b010000, 1500);
        wait_sample(40, got, s);
        check_output("to_first_val", 32'(s.val), 513);
        check_output("to_fs_cleared", 32'(failsafe[4]), 0);
        q.delete();
        got = 1'b0;
        for (int c = 0; c < 27000 && !got; c++) begin
            @(negedge tmr_1Mhz);
            if (failsafe[4] === 1'b1) got = 1'b1;
        end
        check_output("to_fs_set", 32'(got), 1);
        repeat (30) @(posedge tmr_1Mhz);
        n4    = 0;
        n_def = 0;
        foreach (q[k]) begin
            if (q[k].ch == 3'd4) n4++;
            if (q[k].val == 10'd512) n_def++;
        end
        check_output("to_ch4_count", 32'(n4), 1);
        check_output("to_total", 32'(q.size()), 6);
        check_output("to_default_count", 32'(n_def), 6);
        check_output("to_fs_all", 32'(failsafe), 32'h3f);
        q.delete();
        apply_stimulus(6'b010000, 1600);
        wait_sample(40, got, s);
        check_output("to_recover_ch", 32'(s.ch), 4);
        check_output("to_recover_val", 32'(s.val), 613);
        @(negedge tmr_1Mhz);
        check_output("to_recover_fs", 32'(failsafe), 32'h2f);

        // Reset asserted while a sample is held.
        do_reset();
        out_ready = 1'b0;
        apply_stimulus(6'b000100, 1500);
        wait_valid(20, got);
        check_output("rh_valid_before", 32'(got), 1);
        @(posedge tmr_1Mhz) #1 rst_n = 1'b0;
        #2;
        check_output("rh_valid_async", 32'(out_valid), 0);
        check_output("rh_ch", 32'(out_ch), 0);
        check_output("rh_val", 32'(out_val), 0);
        check_output("rh_failsafe", 32'(failsafe), 32'h3f);
        repeat (3) @(posedge tmr_1Mhz);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (60) @(posedge tmr_1Mhz);
        check_output("rh_no_stale", 32'(q.size()), 0);

        $display("[TB] End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
